// File: rtl/ex9_delay_timer_pkg.sv
// Shared definitions for the delay timer: one-hot delay FSM states,
// default timing constants and the BCD increment helper.
package ex9_delay_timer_pkg;

  localparam int DEF_MS_DIV      = 50000;
  localparam int DEF_TICK_MS     = 500;
  localparam int DEF_DELAY_SCALE = 32;
  localparam int DLY_W           = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_DELAY  = 3'b010,
    ST_EXPIRE = 3'b100
  } dly_state_t;

  // Adds one to a 4-digit BCD value, rippling the carry 9 -> 0.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (c) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ex9_delay_timer_if.sv
// Control/status bundle between the sequencing logic and the delay timer.
// No handshake: inputs are levels sampled every rising edge, outputs are registered pulses/levels.
interface ex9_delay_timer_if;
  import ex9_delay_timer_pkg::*;

  logic       start_delay;
  logic [6:0] rnd;
  logic       en_counter;
  logic       reset_counter;
  logic       tick;
  logic       time_out;
  logic [15:0] bcd;
  logic       overflow;
  dly_state_t dbg_state;

  modport master (
    output start_delay, rnd, en_counter, reset_counter,
    input  tick, time_out, bcd, overflow, dbg_state
  );

  modport slave (
    input  start_delay, rnd, en_counter, reset_counter,
    output tick, time_out, bcd, overflow, dbg_state
  );
endinterface

// File: rtl/ex9_bcd4_counter.sv
// Saturating 4-digit BCD reaction-time counter with sticky overflow.
module ex9_bcd4_counter
  import ex9_delay_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_strobe,
  input  logic        i_en,
  input  logic        i_clr,
  output logic [15:0] o_bcd,
  output logic        o_overflow
);

  logic [15:0] r_bcd;
  logic        r_ovf;

  // Clear wins over counting; an increment attempted at 9999 flags overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd <= 16'h0000;
      r_ovf <= 1'b0;
    end else if (i_clr) begin
      r_bcd <= 16'h0000;
      r_ovf <= 1'b0;
    end else if (i_strobe && i_en) begin
      if (r_bcd == 16'h9999) begin
        r_ovf <= 1'b1;
      end else begin
        r_bcd <= bcd_inc(r_bcd);
      end
    end
  end

  assign o_bcd      = r_bcd;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/ex9_delay_timer.sv
// Millisecond prescaler, periodic tick, random-delay FSM and reaction-time counter.
module ex9_delay_timer
  import ex9_delay_timer_pkg::*;
#(
  parameter int MS_DIV      = DEF_MS_DIV,
  parameter int TICK_MS     = DEF_TICK_MS,
  parameter int DELAY_SCALE = DEF_DELAY_SCALE
) (
  input  logic            clk,
  input  logic            rst,
  ex9_delay_timer_if.slave bus
);

  localparam int PRE_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int TK_W  = (TICK_MS > 1) ? $clog2(TICK_MS) : 1;

  logic [PRE_W-1:0] r_pre;
  logic [TK_W-1:0]  r_tick_cnt;
  logic             r_tick;
  logic             r_start_q;
  logic [DLY_W-1:0] r_dly_cnt;
  dly_state_t       r_state;
  dly_state_t       w_next;
  logic             w_ms_strobe;
  logic             w_start_edge;
  logic [6:0]       w_rnd_eff;
  logic [DLY_W-1:0] w_load;

  assign w_ms_strobe  = (r_pre == PRE_W'(MS_DIV - 1));
  assign w_start_edge = bus.start_delay & ~r_start_q;
  assign w_rnd_eff    = (bus.rnd == 7'd0) ? 7'd1 : bus.rnd;
  assign w_load       = DLY_W'({5'd0, w_rnd_eff} * DLY_W'(DELAY_SCALE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else if (w_ms_strobe) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (w_ms_strobe) begin
        if (r_tick_cnt == TK_W'(TICK_MS - 1)) begin
          r_tick_cnt <= '0;
          r_tick     <= 1'b1;
        end else begin
          r_tick_cnt <= r_tick_cnt + TK_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_start_q <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_start_q <= bus.start_delay;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_start_edge) w_next = ST_DELAY;
      ST_DELAY:  if (w_ms_strobe && (r_dly_cnt == DLY_W'(1))) w_next = ST_EXPIRE;
      ST_EXPIRE: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // The strobe coinciding with the load edge is seen while still IDLE, so it never counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dly_cnt <= '0;
    end else if ((r_state == ST_IDLE) && w_start_edge) begin
      r_dly_cnt <= w_load;
    end else if ((r_state == ST_DELAY) && w_ms_strobe) begin
      r_dly_cnt <= r_dly_cnt - DLY_W'(1);
    end
  end

  always_comb begin
    bus.time_out  = (r_state == ST_EXPIRE);
    bus.dbg_state = r_state;
    bus.tick      = r_tick;
  end

  ex9_bcd4_counter u_bcd (
    .clk        (clk),
    .rst        (rst),
    .i_strobe   (w_ms_strobe),
    .i_en       (bus.en_counter),
    .i_clr      (bus.reset_counter),
    .o_bcd      (bus.bcd),
    .o_overflow (bus.overflow)
  );

endmodule

// File: tb/tb_ex9_delay_timer.sv
// Randomized bench for ex9_delay_timer against a cycle-indexed arithmetic reference model.
module tb_ex9_delay_timer;
  import ex9_delay_timer_pkg::*;

  localparam int MS_DIV      = 4;
  localparam int TICK_MS     = 5;
  localparam int DELAY_SCALE = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ex9_delay_timer_if bus ();

  ex9_delay_timer #(
    .MS_DIV      (MS_DIV),
    .TICK_MS     (TICK_MS),
    .DELAY_SCALE (DELAY_SCALE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: cycles counted from reset release; ms k completes at edge k*MS_DIV.
  int m_cyc    = 0;
  int m_cnt    = 0;
  bit m_ovf    = 1'b0;
  bit m_busy   = 1'b0;
  int m_exp_to = 0;
  bit m_prev   = 1'b0;
  int tick_seen = 0;
  int to_seen   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic model_clear();
    m_cyc  = 0;
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_busy = 1'b0;
    m_exp_to = 0;
    m_prev = 1'b0;
  endtask

  task automatic model_edge();
    bit strobe;
    int n;
    m_cyc++;
    strobe = ((m_cyc % MS_DIV) == 0);
    if (bus.reset_counter) begin
      m_cnt = 0;
      m_ovf = 1'b0;
    end else if (strobe && bus.en_counter) begin
      if (m_cnt == 9999) m_ovf = 1'b1;
      else m_cnt++;
    end
    if (bus.start_delay && !m_prev && !m_busy) begin
      n = ((bus.rnd == 7'd0) ? 1 : int'(bus.rnd)) * DELAY_SCALE;
      m_busy   = 1'b1;
      m_exp_to = (m_cyc / MS_DIV + n) * MS_DIV;
    end else if (m_busy && (m_cyc == m_exp_to + 1)) begin
      m_busy = 1'b0;
    end
    m_prev = bus.start_delay;
  endtask

  task automatic step();
    dly_state_t es;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    es = !m_busy ? ST_IDLE : ((m_cyc == m_exp_to) ? ST_EXPIRE : ST_DELAY);
    check("tick", 32'(bus.tick), 32'((m_cyc % (MS_DIV * TICK_MS)) == 0));
    check("time_out", 32'(bus.time_out), 32'(m_busy && (m_cyc == m_exp_to)));
    check("state", 32'(bus.dbg_state), 32'(es));
    check("bcd", 32'(bus.bcd), 32'(to_bcd(m_cnt)));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    if (bus.tick) tick_seen++;
    if (bus.time_out) to_seen++;
  endtask

  task automatic reset_outputs_check(input string tag);
    check({tag, "_tick"}, 32'(bus.tick), 32'(0));
    check({tag, "_time_out"}, 32'(bus.time_out), 32'(0));
    check({tag, "_bcd"}, 32'(bus.bcd), 32'(0));
    check({tag, "_overflow"}, 32'(bus.overflow), 32'(0));
    check({tag, "_state"}, 32'(bus.dbg_state), 32'(ST_IDLE));
  endtask

  // Asynchronous assert from the low phase, checked before any clock edge can act.
  task automatic apply_reset(input string tag);
    rst = 1'b1;
    #1;
    reset_outputs_check(tag);
    repeat (3) @(negedge clk);
    reset_outputs_check({tag, "_hold"});
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    int base;
    int s;
    bus.start_delay   = 1'b0;
    bus.rnd           = 7'd0;
    bus.en_counter    = 1'b0;
    bus.reset_counter = 1'b0;
    @(negedge clk);
    apply_reset("por");

    tick_seen = 0;
    repeat (100) step();
    check("idle_tick_count", 32'(tick_seen), 32'(5));
    check("idle_no_timeout", 32'(to_seen), 32'(0));

    base = to_seen;
    bus.rnd = 7'd3;
    bus.start_delay = 1'b1;
    step();
    bus.start_delay = 1'b0;
    repeat (60) step();
    check("rnd3_pulses", 32'(to_seen - base), 32'(1));

    base = to_seen;
    bus.rnd = 7'd0;
    bus.start_delay = 1'b1;
    step();
    bus.start_delay = 1'b0;
    step();
    bus.rnd = 7'd9;
    bus.start_delay = 1'b1;
    step();
    bus.start_delay = 1'b0;
    repeat (20) step();
    check("rnd0_restart_ignored", 32'(to_seen - base), 32'(1));

    for (int it = 0; it < 300; it++) begin
      bus.start_delay   = ($urandom_range(0, 3) == 0);
      bus.rnd           = 7'($urandom_range(0, (it % 10 == 0) ? 127 : 12));
      bus.en_counter    = 1'($urandom_range(0, 1));
      bus.reset_counter = ($urandom_range(0, 19) == 0);
      repeat ($urandom_range(1, 30)) step();
    end
    bus.start_delay = 1'b0;
    bus.en_counter  = 1'b0;

    bus.reset_counter = 1'b1;
    step();
    bus.reset_counter = 1'b0;
    bus.en_counter    = 1'b1;
    for (int i = 0; i < 20000 && m_cnt < 1234; i++) step();
    bus.en_counter = 1'b0;
    repeat (10) step();
    check("bcd_1234", 32'(bus.bcd), 32'(16'h1234));
    bus.reset_counter = 1'b1;
    bus.en_counter    = 1'b1;
    step();
    bus.reset_counter = 1'b0;
    bus.en_counter    = 1'b0;
    check("clr_dominates", 32'(bus.bcd), 32'(0));

    bus.en_counter = 1'b1;
    s = 0;
    for (int i = 0; i < 60000 && s < 10005; i++) begin
      step();
      if ((m_cyc % MS_DIV) == 0) s++;
    end
    bus.en_counter = 1'b0;
    check("sat_bcd", 32'(bus.bcd), 32'(16'h9999));
    check("sat_overflow", 32'(bus.overflow), 32'(1));
    repeat (20) step();
    check("overflow_sticky", 32'(bus.overflow), 32'(1));
    bus.reset_counter = 1'b1;
    step();
    bus.reset_counter = 1'b0;
    check("overflow_cleared", 32'(bus.overflow), 32'(0));
    check("bcd_cleared", 32'(bus.bcd), 32'(0));

    bus.en_counter = 1'b1;
    repeat (40) step();
    bus.en_counter = 1'b0;
    base = to_seen;
    bus.rnd = 7'd5;
    bus.start_delay = 1'b1;
    step();
    bus.start_delay = 1'b0;
    repeat (12) step();
    #2;
    apply_reset("mid_delay");
    repeat (150) step();
    check("no_timeout_after_abort", 32'(to_seen - base), 32'(0));

    base = to_seen;
    bus.rnd = 7'd1;
    bus.start_delay = 1'b1;
    step();
    #2;
    apply_reset("held_start");
    repeat (20) step();
    bus.start_delay = 1'b0;
    repeat (5) step();
    check("held_start_fires", 32'(to_seen - base), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
